// File: rtl/calc_gate_identify_pkg.sv
// Shared codes for the gate identifier: gate codes (calculator output bit index),
// known 4-bit truth patterns indexed by {a,b}, and FSM state encoding.
package calc_gate_identify_pkg;

    localparam logic [2:0] GATE_AND     = 3'd0;
    localparam logic [2:0] GATE_OR      = 3'd1;
    localparam logic [2:0] GATE_NOT_A   = 3'd2;
    localparam logic [2:0] GATE_XOR     = 3'd3;
    localparam logic [2:0] GATE_XNOR    = 3'd4;
    localparam logic [2:0] GATE_NOR     = 3'd5;
    localparam logic [2:0] GATE_NAND    = 3'd6;
    localparam logic [2:0] GATE_UNKNOWN = 3'd7;

    // Bit {a,b} of each pattern is the gate output for that input pair
    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_NOT_A = 4'b0011;
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] TT_XNOR  = 4'b1001;
    localparam logic [3:0] TT_NOR   = 4'b0001;
    localparam logic [3:0] TT_NAND  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROBE  = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

endpackage

// File: rtl/calc_gate_identify_tt_decode.sv
// Combinational truth-table decoder: maps a sampled 4-entry truth table to a gate code.
// The known patterns are disjoint, so case order carries no priority meaning.
module calc_tt_decode
    import calc_gate_identify_pkg::*;
(
    input  logic [3:0] truth,
    output logic [2:0] gate_code,
    output logic       match
);

    always_comb begin
        gate_code = GATE_UNKNOWN;
        match     = 1'b0;
        case (truth)
            TT_AND:   begin gate_code = GATE_AND;   match = 1'b1; end
            TT_OR:    begin gate_code = GATE_OR;    match = 1'b1; end
            TT_NOT_A: begin gate_code = GATE_NOT_A; match = 1'b1; end
            TT_XOR:   begin gate_code = GATE_XOR;   match = 1'b1; end
            TT_XNOR:  begin gate_code = GATE_XNOR;  match = 1'b1; end
            TT_NOR:   begin gate_code = GATE_NOR;   match = 1'b1; end
            TT_NAND:  begin gate_code = GATE_NAND;  match = 1'b1; end
            default:  begin gate_code = GATE_UNKNOWN; match = 1'b0; end
        endcase
    end

endmodule

// File: rtl/calc_gate_identify.sv
// Gate identifier: walks the four operand pairs on probe_a/probe_b, samples resp after a
// settle time into a truth table and decodes which 2-input gate is attached.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for start; results from the last run held
//   ST_PROBE  | driving vector idx, counting settle cycles, sampling resp
//   ST_DECODE | registering gate_code/match, pulsing done, returning to idle
module calc_gate_identify
    import calc_gate_identify_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       probe_a,
    output logic       probe_b,
    input  logic       resp,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth,
    output logic [2:0] gate_code,
    output logic       match
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

    state_t           state;
    logic [1:0]       idx;
    logic [1:0]       idx_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       dec_code;
    logic             dec_match;

    // Wraps to 0 after vector 3, so probes return to 00 for the decode cycle
    assign idx_next = idx + 2'd1;

    calc_tt_decode u_decode (
        .truth     (truth),
        .gate_code (dec_code),
        .match     (dec_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            cnt       <= '0;
            probe_a   <= 1'b0;
            probe_b   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            truth     <= 4'd0;
            gate_code <= GATE_UNKNOWN;
            match     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        truth   <= 4'd0;
                        idx     <= 2'd0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        probe_a <= 1'b0;
                        probe_b <= 1'b0;
                        state   <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    if (cnt == SETTLE_LAST) begin
                        truth[idx] <= resp;
                        idx        <= idx_next;
                        cnt        <= '0;
                        probe_a    <= idx_next[1];
                        probe_b    <= idx_next[0];
                        if (idx == 2'd3) begin
                            state <= ST_DECODE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    gate_code <= dec_code;
                    match     <= dec_match;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    probe_a   <= 1'b0;
                    probe_b   <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_gate_identify.sv
// Bench for calc_gate_identify: behavioural gate models drive resp, expected results are
// queued at start and compared when done pulses.
module tb_calc_gate_identify;
    import calc_gate_identify_pkg::*;

    typedef struct packed {
        logic [3:0] truth;
        logic [2:0] code;
        logic       match;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       probe_a, probe_b, resp, busy, done, match;
    logic       probe_a2, probe_b2, resp2, busy2, done2, match2;
    logic [3:0] truth, truth2;
    logic [2:0] gate_code, gate_code2;
    int         sel = 0;
    int         sel2 = 0;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];
    exp_t sb2[$];
    logic [2:0] prev_code;

    function automatic logic gate_out(int g, logic a, logic b);
        case (g)
            0: return a & b;
            1: return a | b;
            2: return ~a;
            3: return a ^ b;
            4: return ~(a ^ b);
            5: return ~(a | b);
            6: return ~(a & b);
            7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(int g);
        exp_t e;
        logic [1:0] v;
        for (int ab = 0; ab < 4; ab++) begin
            v = 2'(ab);
            e.truth[ab] = gate_out(g, v[1], v[0]);
        end
        e.code  = (g < 7) ? 3'(g) : 3'd7;
        e.match = (g < 7);
        return e;
    endfunction

    assign resp  = gate_out(sel, probe_a, probe_b);
    assign resp2 = gate_out(sel2, probe_a2, probe_b2);

    calc_gate_identify #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .probe_a(probe_a), .probe_b(probe_b),
        .resp(resp), .busy(busy), .done(done), .truth(truth),
        .gate_code(gate_code), .match(match)
    );

    calc_gate_identify #(.SETTLE_CYCLES(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .probe_a(probe_a2), .probe_b(probe_b2),
        .resp(resp2), .busy(busy2), .done(done2), .truth(truth2),
        .gate_code(gate_code2), .match(match2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_truth"}, truth, 0);
        chk({tag, "_code"}, gate_code, 7);
        chk({tag, "_match"}, match, 0);
        chk({tag, "_probes"}, {probe_a, probe_b}, 0);
    endtask

    // One run on the SETTLE_CYCLES=2 instance; k counts negedges after the start edge
    task automatic run(input int g, input int pulse_at, input int rst_at);
        exp_t e;
        int   done_at;
        int   ndone;
        int   perr;
        sel = g;
        sb.push_back(model(g));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        done_at = -1;
        ndone   = 0;
        perr    = 0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) begin
                chk("busy_after_start", busy, 1);
                chk("truth_cleared", truth, 0);
                chk("code_held", gate_code, prev_code);
            end
            if (rst_at < 0 && k < 12 && {probe_a, probe_b} !== 2'(k / 3)) perr++;
            if (rst_at >= 0 && k == rst_at + 1) check_reset_outputs("abort");
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = k;
                    if (sb.size() == 0) chk("sb_empty", 0, 1);
                    else begin
                        e = sb.pop_front();
                        chk($sformatf("truth_g%0d", g), truth, e.truth);
                        chk($sformatf("code_g%0d", g), gate_code, e.code);
                        chk($sformatf("match_g%0d", g), match, e.match);
                        prev_code = e.code;
                    end
                    chk("busy_clear_at_done", busy, 0);
                end
            end
            if (rst_at < 0 && k == 40) chk("code_hold_after_done", gate_code, prev_code);
            if (k == pulse_at) start = 1'b1;
            else if (k == pulse_at + 1) start = 1'b0;
            if (k == rst_at) rst = 1'b1;
            else if (rst_at >= 0 && k == rst_at + 1) rst = 1'b0;
        end
        if (rst_at < 0) begin
            chk("probe_seq", perr, 0);
            chk("done_count", ndone, 1);
            chk("latency", done_at, 13);
        end else begin
            chk("no_done_after_rst", ndone, 0);
            if (sb.size() > 0) void'(sb.pop_front());
            prev_code = 3'd7;
        end
    endtask

    initial begin
        exp_t e;
        int   nd;
        int   first_k;
        int   g2;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        check_reset_outputs("reset_b2b_inst_unused");
        chk("reset_busy2", busy2, 0);
        rst = 1'b0;
        prev_code = 3'd7;

        run(0, -1, -1);
        for (int g = 1; g <= 8; g++) run(g, -1, -1);
        run(3, 5, -1);
        run(4, -1, 7);
        run(6, -1, -1);

        g2 = 0;
        sel2 = 0;
        sb2.push_back(model(0));
        @(negedge clk) start2 = 1'b1;
        nd = 0;
        first_k = -1;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            if (done2) begin
                nd++;
                if (first_k < 0) first_k = k;
                if (sb2.size() == 0) chk("b2b_sb_empty", 0, 1);
                else begin
                    e = sb2.pop_front();
                    chk($sformatf("b2b_truth_g%0d", g2), truth2, e.truth);
                    chk($sformatf("b2b_code_g%0d", g2), gate_code2, e.code);
                    chk($sformatf("b2b_match_g%0d", g2), match2, e.match);
                end
                g2 = (g2 + 1) % 8;
                sel2 = g2;
                sb2.push_back(model(g2));
            end
        end
        start2 = 1'b0;
        chk("b2b_first_latency", first_k, 5);
        chk("b2b_done_count_ge4", (nd >= 4), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
